calc_status_ctrl: RTL and testbench

// Operation-status tracker between the matrix compute/parse logic and led_status.

---
 rtl/calc_status_ctrl_pkg.sv | 26 ++
 rtl/calc_status_ctrl_watchdog_timer.sv | 33 +++
 rtl/calc_status_ctrl.sv | 155 +++++++++++++++
 tb/tb_calc_status_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_status_ctrl_pkg.sv
// Shared definitions for the operation-status tracker: FSM state encoding,
// latched error codes and the raw-code to stored-code mapping.
package calc_status_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_ERROR = 2'b10
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'b000;
  localparam logic [2:0] ERR_GENERIC = 3'b001;
  localparam logic [2:0] ERR_TIMEOUT = 3'b111;

  // A zero fault code would read as "no error", so it is promoted to GENERIC.
  function automatic logic [2:0] map_err_code(input logic [2:0] code);
    logic [2:0] res;
    if (code == ERR_NONE) begin
      res = ERR_GENERIC;
    end else begin
      res = code;
    end
    return res;
  endfunction

endpackage

// File: rtl/calc_status_ctrl_watchdog_timer.sv
// Watchdog counter for the BUSY state: cleared on entry, advanced while
// enabled, and signals expiry when the count reaches LIMIT-1.
import calc_status_ctrl_pkg::*;

module watchdog_timer #(
  parameter int LIMIT = 5_000_000,
  parameter int W     = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [W-1:0] count_r;

  // Elapsed-cycle counter; clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (en) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == W'(LIMIT - 1));

endmodule

// File: rtl/calc_status_ctrl.sv
// Operation-status tracker: turns start/done/error pulses into mutually
// exclusive busy/done/error flags, latches the first fault code until it is
// acknowledged, times out hung operations and counts completions.
import calc_status_ctrl_pkg::*;

module calc_status_ctrl #(
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int TMR_W          = 23,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_start,
  input  logic             op_done,
  input  logic             op_error,
  input  logic [2:0]       op_err_code,
  input  logic             err_clear,
  output logic             busy_flag,
  output logic             done_flag,
  output logic             error_flag,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] op_count
);

  state_t             state_r;
  state_t             state_s;
  logic               wd_clr_s;
  logic               wd_en_s;
  logic               wd_expire_s;
  logic [2:0]         code_s;
  logic               done_s;
  logic [CNT_W-1:0]   count_s;

  // The timer restarts on every entry into BUSY and only runs while BUSY.
  assign wd_clr_s = (state_r != ST_BUSY) && (state_s == ST_BUSY);
  assign wd_en_s  = (state_r == ST_BUSY);

  watchdog_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TMR_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr_s),
    .en     (wd_en_s),
    .expire (wd_expire_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; faults always win over completion or launch.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (op_error) begin
          state_s = ST_ERROR;
        end else if (op_start) begin
          state_s = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (op_error) begin
          state_s = ST_ERROR;
        end else if (op_done) begin
          state_s = ST_IDLE;
        end else if (wd_expire_s) begin
          state_s = ST_ERROR;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_ERROR: begin
        if (err_clear) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ERROR;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next values for the code latch, done pulse and completion counter.
  always_comb begin
    code_s  = err_code;
    done_s  = 1'b0;
    count_s = op_count;
    case (state_r)
      ST_IDLE: begin
        if (op_error) begin
          code_s = map_err_code(op_err_code);
        end else begin
          code_s = ERR_NONE;
        end
      end
      ST_BUSY: begin
        if (op_error) begin
          code_s = map_err_code(op_err_code);
        end else if (op_done) begin
          done_s = 1'b1;
          if (op_count != {CNT_W{1'b1}}) begin
            count_s = op_count + CNT_W'(1);
          end else begin
            count_s = op_count;
          end
        end else if (wd_expire_s) begin
          code_s = ERR_TIMEOUT;
        end else begin
          code_s = err_code;
        end
      end
      ST_ERROR: begin
        if (err_clear) begin
          code_s = ERR_NONE;
        end else begin
          code_s = err_code;
        end
      end
      default: begin
        code_s = ERR_NONE;
      end
    endcase
  end

  // Output registers; flags follow the state being entered so they line up
  // with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_flag  <= 1'b0;
      done_flag  <= 1'b0;
      error_flag <= 1'b0;
      err_code   <= ERR_NONE;
      op_count   <= {CNT_W{1'b0}};
    end else begin
      busy_flag  <= (state_s == ST_BUSY);
      done_flag  <= done_s;
      error_flag <= (state_s == ST_ERROR);
      err_code   <= code_s;
      op_count   <= count_s;
    end
  end

endmodule

// File: tb/tb_calc_status_ctrl.sv
// Self-checking bench for calc_status_ctrl: directed scenarios plus random
// pulse traffic, all compared cycle by cycle against a behavioural model.
module tb_calc_status_ctrl;

  localparam int TIMEOUT = 20;
  localparam int CW      = 8;
  localparam int CMAX    = 255;

  logic          clk;
  logic          rst;
  logic          op_start;
  logic          op_done;
  logic          op_error;
  logic [2:0]    op_err_code;
  logic          err_clear;
  logic          busy_flag;
  logic          done_flag;
  logic          error_flag;
  logic [2:0]    err_code;
  logic [CW-1:0] op_count;

  int n_checks;
  int n_pass;

  // Behavioural model: which activity is running, how long it has run,
  // the stored code and the completion tally.
  bit m_running;
  bit m_faulted;
  bit m_done;
  int m_age;
  int m_code;
  int m_count;

  calc_status_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .TMR_W          (23),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .op_start    (op_start),
    .op_done     (op_done),
    .op_error    (op_error),
    .op_err_code (op_err_code),
    .err_clear   (err_clear),
    .busy_flag   (busy_flag),
    .done_flag   (done_flag),
    .error_flag  (error_flag),
    .err_code    (err_code),
    .op_count    (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 1'b0;
    m_faulted = 1'b0;
    m_done    = 1'b0;
    m_age     = 0;
    m_code    = 0;
    m_count   = 0;
  endtask

  // Apply one cycle of input events to the model.
  task automatic model_step(input bit s, input bit d, input bit e,
                            input int c, input bit clr);
    m_done = 1'b0;
    if (m_faulted) begin
      if (clr) begin
        m_faulted = 1'b0;
        m_code    = 0;
      end
    end else if (m_running) begin
      if (e) begin
        m_running = 1'b0;
        m_faulted = 1'b1;
        m_code    = (c == 0) ? 1 : c;
      end else if (d) begin
        m_running = 1'b0;
        m_done    = 1'b1;
        if (m_count < CMAX) m_count = m_count + 1;
      end else if (m_age == TIMEOUT - 1) begin
        m_running = 1'b0;
        m_faulted = 1'b1;
        m_code    = 7;
      end else begin
        m_age = m_age + 1;
      end
    end else begin
      if (e) begin
        m_faulted = 1'b1;
        m_code    = (c == 0) ? 1 : c;
      end else if (s) begin
        m_running = 1'b1;
        m_age     = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".busy"}, int'(busy_flag), int'(m_running));
    check_eq({tag, ".done"}, int'(done_flag), int'(m_done));
    check_eq({tag, ".error"}, int'(error_flag), int'(m_faulted));
    check_eq({tag, ".code"}, int'(err_code), m_code);
    check_eq({tag, ".count"}, int'(op_count), m_count);
    check_eq({tag, ".excl"}, int'($countones({busy_flag, done_flag, error_flag}) <= 1), 1);
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model.
  task automatic step(input string tag, input bit s, input bit d, input bit e,
                      input logic [2:0] c, input bit clr);
    op_start    = s;
    op_done     = d;
    op_error    = e;
    op_err_code = c;
    err_clear   = clr;
    @(posedge clk);
    #1;
    model_step(s, d, e, int'(c), clr);
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  int busy_seen;
  int pulses;
  bit s_r, d_r, e_r, c_r;
  logic [2:0] code_r;

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst         = 1'b1;
    op_start    = 1'b0;
    op_done     = 1'b0;
    op_error    = 1'b0;
    op_err_code = 3'b000;
    err_clear   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b0;
    idle("post_reset", 2);

    // 1: start, done five cycles later.
    busy_seen = 0;
    step("t1_start", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    busy_seen += int'(busy_flag);
    for (int i = 0; i < 4; i++) begin
      step("t1_wait", 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      busy_seen += int'(busy_flag);
    end
    step("t1_done", 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    check_eq("t1_busy_cycles", busy_seen, 5);
    check_eq("t1_done_pulse", int'(done_flag), 1);
    idle("t1_after", 1);
    check_eq("t1_done_low", int'(done_flag), 0);

    // 2: start with no done, watchdog must fire after 20 busy cycles.
    busy_seen = 0;
    step("t2_start", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 40 && !error_flag; i++) begin
      busy_seen += int'(busy_flag);
      step("t2_wait", 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    end
    check_eq("t2_timeout_seen", int'(error_flag), 1);
    check_eq("t2_busy_cycles", busy_seen, TIMEOUT);
    check_eq("t2_code", int'(err_code), 7);
    step("t2_clear", 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    check_eq("t2_cleared", int'(error_flag), 0);

    // 3: done and error together while busy.
    step("t3_start", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    idle("t3_wait", 2);
    step("t3_both", 1'b0, 1'b1, 1'b1, 3'b010, 1'b0);
    check_eq("t3_code", int'(err_code), 2);
    check_eq("t3_no_done", int'(done_flag), 0);
    step("t3_ignored", 1'b1, 1'b1, 1'b1, 3'b101, 1'b0);
    step("t3_clear", 1'b0, 1'b0, 1'b0, 3'b000, 1'b1);

    // 4: parse fault with code 0 from idle, then clear+start together.
    step("t4_err0", 1'b1, 1'b0, 1'b1, 3'b000, 1'b0);
    check_eq("t4_code", int'(err_code), 1);
    step("t4_clr_start", 1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
    check_eq("t4_no_busy", int'(busy_flag), 0);
    idle("t4_after", 2);

    // 5: asynchronous reset three cycles into an operation.
    step("t5_start", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    idle("t5_wait", 2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("t5_async_busy", int'(busy_flag), 0);
    compare_all("t5_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle("t5_after", 4);

    // 6: 300 start/done pairs saturate the counter.
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      step("t6_start", 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
      step("t6_done", 1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
      pulses += int'(done_flag);
    end
    check_eq("t6_pulses", pulses, 300);
    check_eq("t6_saturated", int'(op_count), CMAX);

    // Random pulse traffic.
    for (int i = 0; i < 1500; i++) begin
      s_r    = ($urandom_range(0, 99) < 30);
      d_r    = ($urandom_range(0, 99) < 12);
      e_r    = ($urandom_range(0, 99) < 4);
      c_r    = ($urandom_range(0, 99) < 20);
      code_r = 3'($urandom_range(0, 7));
      step("rand", s_r, d_r, e_r, code_r, c_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
